uart_fifo_core: RTL and testbench
=================================

// Module: uart_fifo_core
// PURPOSE
//   Parametrised full-duplex UART: internal baud divider, 16x-oversampled receiver,
//   transmitter, and one FIFO per direction. Replaces the fixed 8N1 baud/rx/tx trio
//   under the debug unit with a configurable, buffered serial core.
// PARAMETERS
//   CLK_HZ      50_000_000  system clock frequency
//   BAUD        115200      line rate; DIV = CLK_HZ/(BAUD*16), integer-truncated, min 1
//   DATA_BITS   8           data bits per frame, 5..9
//   STOP_BITS   1           stop bits, 1 or 2
//   FIFO_DEPTH  16          entries per FIFO, power of two, >=2
//   PARITY_ODD  0           0 = even parity, 1 = odd (used only with UART_PARITY_EN)
// PORTS
//   clk        in   1          system clock, rising edge
//   rst_n      in   1          asynchronous active-low reset
//   rx         in   1          serial input, asynchronous, idle high
//   tx         out  1          serial output, idle high
//   wr_en      in   1          push wr_data to TX FIFO
//   wr_data    in   DATA_BITS  byte to transmit
//   tx_full    out  1          TX FIFO full
//   tx_busy    out  1          frame on line or TX FIFO not empty
//   rd_en      in   1          pop RX FIFO head
//   rd_data    out  DATA_BITS  RX FIFO head (first-word-fall-through)
//   rx_empty   out  1          RX FIFO empty
//   frame_err  out  1          1-cycle pulse: stop bit sampled low
//   parity_err out  1          1-cycle pulse: parity mismatch
//   overrun    out  1          sticky: byte dropped on full RX FIFO; clears on rd_en
// BEHAVIOUR
//   Reset (async assert, sync release): tx=1, tx_full=0, tx_busy=0, rx_empty=1,
//     rd_data=0, all error flags 0, FIFOs emptied, both FSMs IDLE, divider=0.
//   Tick: counter 0..DIV-1, one-cycle tick at DIV-1; free-running, shared by RX and TX.
//   RX: rx through 2-FF synchroniser. IDLE -> START on falling edge; START re-samples
//     at tick 7, goes to IDLE if high (glitch); else DATA, sampling every 16 ticks, LSB
//     first; [PARITY]; STOP samples first stop bit only. Stop high -> push; stop low ->
//     frame_err pulse, byte discarded. Back to IDLE after the stop sample.
//   TX: IDLE pops FIFO when non-empty, same cycle; START(0), DATA LSB first, [PARITY],
//     STOP x STOP_BITS; 16 ticks per bit. Next frame starts in the cycle after the last stop.
//   FIFOs: pointers are log2(FIFO_DEPTH)+1 bits; full/empty are decided by the MSB.
//     Pointers wrap modulo 2*FIFO_DEPTH. wr_en on full is ignored. rd_en on empty is ignored.
//     Push and pop in the same cycle: both take effect, and the count is unchanged.
//     For the RX FIFO, push and pop when full are also allowed. Flags are registered and
//     update in the cycle after the operation. rd_data is valid whenever rx_empty=0.
//   Overrun: RX push on a full FIFO with no pop that cycle -> byte dropped, overrun=1.
//     rd_en in the same cycle as an overrun: pop occurs, and overrun is set (set wins).
//   Reset mid-frame: tx returns to 1 immediately; the partial RX frame is discarded.
// CONFIGURATION
//   UART_PARITY_EN defined: one parity bit after data (even/odd per PARITY_ODD).
//     On RX mismatch: parity_err pulse, byte discarded. If the stop bit is also low,
//     frame_err and parity_err pulse together.
//   UART_PARITY_EN undefined: no parity bit in either direction; parity_err tied 0.
// TESTING
//   Setup: default parameters, DIV=27, bit period 432 clk.
//   1. Reset, then wr_en with wr_data=8'hA5 -> tx: 0,1,0,1,0,0,1,0,1,1,
//      432 clk per bit; tx_busy falls after the stop bit.
//   2. Loopback tx->rx, write 8'h00, 8'hFF, 8'h3C -> rd_data returns the same
//      three values in order; rx_empty=1 after 3 rd_en.
//   3. FIFO_DEPTH=4, drive 5 frames on rx with no reads -> first 4 retained,
//      overrun=1; one rd_en -> rd_data=1st byte, overrun=0.
//   4. rx frame 8'h55 with stop bit low -> frame_err one pulse; rx_empty stays 1.
//   5. UART_PARITY_EN, PARITY_ODD=0, rx 8'h07 with parity bit 0 -> parity_err
//      pulse, byte discarded; with parity bit 1 -> byte 8'h07 pushed.
//   6. rst_n low at data bit 3 of a TX frame -> tx=1 the same cycle; after release
//      tx_busy=0 and rx_empty=1.

Source files
------------

// File: rtl/uart_fifo_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_core
// Brief    : Full-duplex UART with shared 16x baud tick, oversampled receiver,
//            transmitter and one FIFO per direction. Optional parity bit is
//            enabled by defining UART_PARITY_EN.
// Revision : 1.0
// ============================================================================

module uart_fifo_core_fifo #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter bit FULL_PUSH_POP = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr, r_rptr;
    logic [AW:0]      w_wptr_nxt, w_rptr_nxt;
    logic             r_full, r_empty;
    logic             w_push, w_pop;

    assign w_pop      = i_pop & ~r_empty;
    assign w_push     = i_push & (~r_full | (FULL_PUSH_POP & w_pop));
    assign w_wptr_nxt = r_wptr + {{AW{1'b0}}, w_push};
    assign w_rptr_nxt = r_rptr + {{AW{1'b0}}, w_pop};

    // Same index with differing wrap bit means full; identical pointers mean empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_empty <= (w_wptr_nxt == w_rptr_nxt);
            r_full  <= (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                       (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

    assign o_data  = r_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign o_full  = r_full;
    assign o_empty = r_empty;
endmodule

module uart_fifo_core #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 tx_full,
    output logic                 tx_busy,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rx_empty,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);
`ifdef UART_PARITY_EN
    localparam bit c_PAR_EN = 1'b1;
`else
    localparam bit c_PAR_EN = 1'b0;
`endif
    localparam bit       c_PAR_ODD = (PARITY_ODD != 0);
    localparam int       c_DIV_RAW = CLK_HZ / (BAUD * 16);
    localparam int       c_DIV     = (c_DIV_RAW < 1) ? 1 : c_DIV_RAW;
    localparam int       c_DIV_W   = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam bit [3:0] c_LAST    = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    logic [1:0]           r_rst_sync;
    logic                 w_rst_n;
    logic [c_DIV_W-1:0]   r_div;
    logic                 w_tick;
    logic                 r_rx_meta, r_rx_sync, r_rx_prev;
    state_t               r_rx_state, w_rx_next, r_tx_state, w_tx_next;
    logic [3:0]           r_rx_tcnt, r_rx_bcnt, r_tx_tcnt, r_tx_bcnt;
    logic [DATA_BITS-1:0] r_rx_shift, r_tx_shift, w_tx_head;
    logic                 r_rx_par_bad, r_tx_par, r_tx_scnt;
    logic                 w_rx_sample, w_rx_push, w_fe_set, w_pe_set;
    logic                 w_tx_bit_end, w_tx_pop, w_tx_line, w_tx_empty, w_rx_full;
    logic                 r_tx, r_tx_busy, r_frame_err, r_parity_err, r_overrun, w_ovr_set;

    // Asynchronous assertion, release aligned to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_tick = (r_div == c_DIV_W'(c_DIV - 1));

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_div <= '0;
        else          r_div <= w_tick ? '0 : r_div + 1'b1;
    end

    // ---------------- Receiver ----------------
    assign w_rx_sample = w_tick &&
        (r_rx_tcnt == ((r_rx_state == ST_START) ? 4'd7 : 4'd15));

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_rx_state <= ST_IDLE;
        else          r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_push = 1'b0;
        w_fe_set  = 1'b0;
        w_pe_set  = 1'b0;
        case (r_rx_state)
            ST_IDLE:   if (r_rx_prev && !r_rx_sync) w_rx_next = ST_START;
            ST_START:  if (w_rx_sample) w_rx_next = r_rx_sync ? ST_IDLE : ST_DATA;
            ST_DATA:   if (w_rx_sample && r_rx_bcnt == c_LAST)
                           w_rx_next = c_PAR_EN ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_rx_sample) w_rx_next = ST_STOP;
            ST_STOP: begin
                if (w_rx_sample) begin
                    w_rx_next = ST_IDLE;
                    w_fe_set  = ~r_rx_sync;
                    w_pe_set  = c_PAR_EN & r_rx_par_bad;
                    w_rx_push = r_rx_sync & ~w_pe_set;
                end
            end
            default:   w_rx_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_rx_tcnt    <= '0;
            r_rx_bcnt    <= '0;
            r_rx_shift   <= '0;
            r_rx_par_bad <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_rx_meta    <= rx;
            r_rx_sync    <= r_rx_meta;
            r_rx_prev    <= r_rx_sync;
            r_frame_err  <= w_fe_set;
            r_parity_err <= w_pe_set;
            if (r_rx_state == ST_IDLE)  r_rx_tcnt <= '0;
            else if (w_tick)            r_rx_tcnt <= w_rx_sample ? 4'd0 : r_rx_tcnt + 4'd1;
            if (r_rx_state == ST_START) r_rx_bcnt <= '0;
            else if (r_rx_state == ST_DATA && w_rx_sample) begin
                r_rx_bcnt  <= r_rx_bcnt + 4'd1;
                r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
            end
            if (r_rx_state == ST_START) r_rx_par_bad <= 1'b0;
            else if (r_rx_state == ST_PARITY && w_rx_sample)
                r_rx_par_bad <= (r_rx_sync != ((^r_rx_shift) ^ c_PAR_ODD));
        end
    end

    // A push that finds the FIFO full and no pop to make room is lost.
    assign w_ovr_set = w_rx_push & w_rx_full & ~(rd_en & ~rx_empty);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n)      r_overrun <= 1'b0;
        else if (w_ovr_set) r_overrun <= 1'b1;
        else if (rd_en)    r_overrun <= 1'b0;
    end

    uart_fifo_core_fifo #(
        .WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH), .FULL_PUSH_POP(1'b1)
    ) u_rx_fifo (
        .clk(clk), .rst_n(w_rst_n), .i_push(w_rx_push), .i_data(r_rx_shift),
        .i_pop(rd_en), .o_data(rd_data), .o_full(w_rx_full), .o_empty(rx_empty)
    );

    // ---------------- Transmitter ----------------
    assign w_tx_bit_end = w_tick && (r_tx_tcnt == 4'd15);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_tx_state <= ST_IDLE;
        else          r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_pop  = 1'b0;
        w_tx_line = 1'b1;
        case (r_tx_state)
            ST_IDLE: begin
                if (!w_tx_empty) begin
                    w_tx_pop  = 1'b1;
                    w_tx_next = ST_START;
                end
            end
            ST_START: begin
                w_tx_line = 1'b0;
                if (w_tx_bit_end) w_tx_next = ST_DATA;
            end
            ST_DATA: begin
                w_tx_line = r_tx_shift[0];
                if (w_tx_bit_end && r_tx_bcnt == c_LAST)
                    w_tx_next = c_PAR_EN ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                w_tx_line = r_tx_par;
                if (w_tx_bit_end) w_tx_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_tx_bit_end && r_tx_scnt == 1'(STOP_BITS - 1)) w_tx_next = ST_IDLE;
            end
            default: w_tx_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_tx_tcnt  <= '0;
            r_tx_bcnt  <= '0;
            r_tx_scnt  <= 1'b0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx       <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else begin
            r_tx      <= w_tx_line;
            r_tx_busy <= (r_tx_state != ST_IDLE) | ~w_tx_empty;
            if (r_tx_state == ST_IDLE) begin
                r_tx_tcnt <= '0;
                r_tx_bcnt <= '0;
                r_tx_scnt <= 1'b0;
            end else if (w_tick) begin
                r_tx_tcnt <= r_tx_tcnt + 4'd1;
            end
            if (w_tx_pop) begin
                r_tx_shift <= w_tx_head;
                r_tx_par   <= (^w_tx_head) ^ c_PAR_ODD;
            end else if (r_tx_state == ST_DATA && w_tx_bit_end) begin
                r_tx_shift <= r_tx_shift >> 1;
                r_tx_bcnt  <= r_tx_bcnt + 4'd1;
            end
            if (r_tx_state == ST_STOP && w_tx_bit_end) r_tx_scnt <= r_tx_scnt + 1'b1;
        end
    end

    uart_fifo_core_fifo #(
        .WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH), .FULL_PUSH_POP(1'b0)
    ) u_tx_fifo (
        .clk(clk), .rst_n(w_rst_n), .i_push(wr_en), .i_data(wr_data),
        .i_pop(w_tx_pop), .o_data(w_tx_head), .o_full(tx_full), .o_empty(w_tx_empty)
    );

    assign tx         = r_tx;
    assign tx_busy    = r_tx_busy;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
endmodule

`default_nettype wire

// File: tb/tb_uart_fifo_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fifo_core
// Brief    : Directed self-checking bench for uart_fifo_core (default build,
//            plus the parity case when UART_PARITY_EN is defined).
// Revision : 1.0
// ============================================================================
module tb_uart_fifo_core;
    localparam int c_BIT = 432;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       r_loop = 1'b0;
    logic       r_rx0 = 1'b1, r_rx1 = 1'b1;
    logic       wr_en = 1'b0, rd_en = 1'b0, rd_en1 = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       w_rx0;
    logic       tx0, tx_full0, tx_busy0, rx_empty0, fe0, pe0, ovr0;
    logic [7:0] rd_data0;
    logic       tx1, tx_full1, tx_busy1, rx_empty1, fe1, pe1, ovr1;
    logic [7:0] rd_data1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_fe0    = 0;
    int n_pe0    = 0;

    assign w_rx0 = r_loop ? tx0 : r_rx0;

    uart_fifo_core u_dut (
        .clk(clk), .rst_n(rst_n), .rx(w_rx0), .tx(tx0),
        .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full0), .tx_busy(tx_busy0),
        .rd_en(rd_en), .rd_data(rd_data0), .rx_empty(rx_empty0),
        .frame_err(fe0), .parity_err(pe0), .overrun(ovr0)
    );

    uart_fifo_core #(.FIFO_DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .rx(r_rx1), .tx(tx1),
        .wr_en(1'b0), .wr_data(8'h00), .tx_full(tx_full1), .tx_busy(tx_busy1),
        .rd_en(rd_en1), .rd_data(rd_data1), .rx_empty(rx_empty1),
        .frame_err(fe1), .parity_err(pe1), .overrun(ovr1)
    );

    always @(negedge clk) begin
        if (fe0) n_fe0++;
        if (pe0) n_pe0++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic drive_bit(input int which, input logic v);
        if (which == 0) r_rx0 = v;
        else            r_rx1 = v;
        repeat (c_BIT) @(negedge clk);
    endtask

    task automatic rx_frame(input int which, input logic [7:0] d, input logic stop_v, input logic par_v);
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
`ifdef UART_PARITY_EN
        drive_bit(which, par_v);
`endif
        drive_bit(which, stop_v);
        drive_bit(which, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pop0();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop1();
        rd_en1 = 1'b1;
        @(negedge clk);
        rd_en1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_tx_fall(input string tag);
        int t;
        t = 0;
        while (tx0 !== 1'b0 && t < 200) begin @(negedge clk); t++; end
        check_val(tag, 32'(t < 200), 32'd1);
    endtask

    task automatic wait_rx_data(input string tag);
        int t;
        t = 0;
        while (rx_empty0 !== 1'b0 && t < 6000) begin @(negedge clk); t++; end
        check_val(tag, 32'(t < 6000), 32'd1);
    endtask

    logic cap  [5000];
    logic capb [5000];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:10] exp_a5;
        logic [7:0]  exp_q [3];
        logic [7:0]  ovr_bytes [5];
        int          n_bits, r0, r2, bf, fe_snap, pe_snap;

`ifdef UART_PARITY_EN
        exp_a5 = 11'b01010010101;
        n_bits = 11;
`else
        exp_a5 = 11'b01010010110;
        n_bits = 10;
`endif
        // ---- Reset state ----
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_val("rst_tx",        tx0,       1);
        check_val("rst_tx_full",   tx_full0,  0);
        check_val("rst_tx_busy",   tx_busy0,  0);
        check_val("rst_rx_empty",  rx_empty0, 1);
        check_val("rst_rd_data",   rd_data0,  0);
        check_val("rst_frame_err", fe0,       0);
        check_val("rst_parity_err", pe0,      0);
        check_val("rst_overrun",   ovr0,      0);

        // ---- Test 1: transmit 8'hA5 ----
        send_byte(8'hA5);
        wait_tx_fall("t1_start_seen");
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            cap[i]  = tx0;
            capb[i] = tx_busy0;
        end
        for (int k = 0; k < n_bits; k++)
            check_val($sformatf("t1_bit%0d", k), cap[216 + k * c_BIT], exp_a5[k]);
        r0 = -1; r2 = -1; bf = -1;
        for (int i = 1; i < 5000; i++) begin
            if (r0 < 0 && cap[i] == 1'b1) r0 = i;
            else if (r0 >= 0 && r2 < 0 && cap[i-1] == 1'b0 && cap[i] == 1'b1) r2 = i;
            if (bf < 0 && capb[i] == 1'b0) bf = i;
        end
        check_val("t1_two_bit_period", r2 - r0, 2 * c_BIT);
        check_val("t1_busy_mid",       capb[2000], 1);
        check_val("t1_busy_fall",      bf - r0, (n_bits - 1) * c_BIT);

        // ---- Test 2: loopback 00, FF, 3C ----
        r_loop = 1'b1;
        exp_q[0] = 8'h00; exp_q[1] = 8'hFF; exp_q[2] = 8'h3C;
        for (int i = 0; i < 3; i++) send_byte(exp_q[i]);
        for (int i = 0; i < 3; i++) begin
            wait_rx_data($sformatf("t2_arrive%0d", i));
            check_val($sformatf("t2_data%0d", i), rd_data0, exp_q[i]);
            pop0();
        end
        check_val("t2_rx_empty", rx_empty0, 1);
        repeat (600) @(negedge clk);
        check_val("t2_tx_idle", tx_busy0, 0);

        // ---- Test 4: stop bit low ----
        r_loop = 1'b0;
        fe_snap = n_fe0; pe_snap = n_pe0;
        rx_frame(0, 8'h55, 1'b0, even_par(8'h55));
        check_val("t4_fe_pulses", n_fe0 - fe_snap, 1);
        check_val("t4_pe_pulses", n_pe0 - pe_snap, 0);
        check_val("t4_rx_empty",  rx_empty0, 1);

        // ---- Test 3: overrun on depth-4 FIFO ----
        ovr_bytes[0] = 8'h11; ovr_bytes[1] = 8'h22; ovr_bytes[2] = 8'h33;
        ovr_bytes[3] = 8'h44; ovr_bytes[4] = 8'h55;
        for (int i = 0; i < 5; i++) rx_frame(1, ovr_bytes[i], 1'b1, even_par(ovr_bytes[i]));
        check_val("t3_overrun_set", ovr1,      1);
        check_val("t3_not_empty",   rx_empty1, 0);
        check_val("t3_head",        rd_data1,  8'h11);
        pop1();
        check_val("t3_overrun_clr", ovr1, 0);
        for (int i = 1; i < 4; i++) begin
            check_val($sformatf("t3_data%0d", i), rd_data1, ovr_bytes[i]);
            pop1();
        end
        check_val("t3_drained", rx_empty1, 1);

        // ---- Test 6: reset in the middle of a frame ----
        r_loop = 1'b1;
        send_byte(8'h00);
        wait_tx_fall("t6_start_seen");
        repeat (216 + 4 * c_BIT) @(negedge clk);
        check_val("t6_tx_bit3", tx0, 0);
        #1 rst_n = 1'b0;
        #1 check_val("t6_tx_async", tx0, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_val("t6_busy",     tx_busy0,  0);
        check_val("t6_rx_empty", rx_empty0, 1);
        repeat (2000) @(negedge clk);
        check_val("t6_rx_still_empty", rx_empty0, 1);
        check_val("t6_tx_idle",        tx0,       1);

`ifdef UART_PARITY_EN
        // ---- Test 5: parity mismatch and match ----
        r_loop = 1'b0;
        fe_snap = n_fe0; pe_snap = n_pe0;
        rx_frame(0, 8'h07, 1'b1, 1'b0);
        check_val("t5_pe_pulses", n_pe0 - pe_snap, 1);
        check_val("t5_fe_pulses", n_fe0 - fe_snap, 0);
        check_val("t5_discarded", rx_empty0, 1);
        rx_frame(0, 8'h07, 1'b1, 1'b1);
        check_val("t5_pe_pulses2", n_pe0 - pe_snap, 1);
        check_val("t5_pushed",     rx_empty0, 0);
        check_val("t5_data",       rd_data0,  8'h07);
        pop0();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
